// File: rtl/imem_loader_pkg.sv
// Shared state encoding, frame constants and address helper for the
// instruction-memory byte-stream loader.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LEN   = 3'd1,
        DATA  = 3'd2,
        CHK   = 3'd3,
        DONE  = 3'd4,
        ERROR = 3'd5
    } state_t;

    localparam int WORD_BYTES    = 4;
    localparam int MAX_WORDS_DEF = 16384;
    localparam int LEN_BYTES     = 4;
    localparam int CHK_BYTES     = 1;

    // Byte address of word idx; wraps modulo 2^32.
    function automatic logic [31:0] word_addr(input logic [31:0] base,
                                              input logic [31:0] idx);
        return base + idx * 32'(WORD_BYTES);
    endfunction

endpackage

// File: rtl/imem_word_assembler.sv
// Packs payload bytes little-endian into 32-bit words, keeps the XOR checksum
// of the payload and emits a one-cycle pulse alongside each completed word.
module imem_word_assembler
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        accept,
    input  logic [7:0]  in_byte,
    output logic        word_last,
    output logic        word_vld_p1,
    output logic [31:0] word_p1,
    output logic [7:0]  csum
);

    logic [1:0]  idx_p0;
    logic [23:0] lo_bytes_p0;

    assign word_last = accept && (idx_p0 == 2'(WORD_BYTES - 1));

    // Stage 0: byte index and running checksum
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_p0 <= '0;
            csum   <= '0;
        end else if (clear) begin
            idx_p0 <= '0;
            csum   <= '0;
        end else if (accept) begin
            idx_p0 <= idx_p0 + 2'd1;
            csum   <= csum ^ in_byte;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            case (idx_p0)
                2'd0:    lo_bytes_p0[7:0]   <= in_byte;
                2'd1:    lo_bytes_p0[15:8]  <= in_byte;
                2'd2:    lo_bytes_p0[23:16] <= in_byte;
                default: ;
            endcase
        end
    end

    // Stage 1: completed word, held until the next one completes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word_vld_p1 <= 1'b0;
            word_p1     <= '0;
        end else begin
            word_vld_p1 <= word_last;
            if (word_last) begin
                word_p1 <= {in_byte, lo_bytes_p0};
            end
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Write side of the instruction memory: parses a length/payload/checksum byte
// frame, writes consecutive words and holds the CPU in reset until success.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MAX_WORDS = MAX_WORDS_DEF,
    parameter int          CNT_W     = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             in_valid,
    input  logic [7:0]       in_byte,
    output logic             in_ready,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic             cpu_hold,
    output logic [CNT_W-1:0] words_written
);

    state_t      state, state_nxt;
    logic [31:0] len;
    logic [1:0]  len_idx;
    logic [31:0] len_full;
    logic        acc;
    logic        start_ok;
    logic        len_acc;
    logic        len_last;
    logic        data_acc;
    logic        word_last;
    logic        last_word;
    logic        word_vld_p1;
    logic [31:0] word_p1;
    logic [7:0]  csum;

    assign busy     = (state == LEN) || (state == DATA) || (state == CHK);
    assign in_ready = busy;
    assign done     = (state == DONE);
    assign error    = (state == ERROR);
    assign cpu_hold = (state != DONE);

    assign acc      = in_valid && in_ready;
    assign start_ok = start && !busy;
    assign len_acc  = acc && (state == LEN);
    assign len_last = len_acc && (len_idx == 2'(LEN_BYTES - 1));
    assign len_full = {in_byte, len[23:0]};
    assign data_acc = acc && (state == DATA);
    // len already holds the full count once DATA is entered
    assign last_word = word_last && (32'(words_written) == len - 32'd1);

    imem_word_assembler u_asm (
        .clk         (clk),
        .reset       (reset),
        .clear       (start_ok),
        .accept      (data_acc),
        .in_byte     (in_byte),
        .word_last   (word_last),
        .word_vld_p1 (word_vld_p1),
        .word_p1     (word_p1),
        .csum        (csum)
    );

    assign mem_we    = word_vld_p1;
    assign mem_wdata = word_p1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE, ERROR: begin
                if (start) begin
                    state_nxt = LEN;
                end
            end
            LEN: begin
                if (len_last) begin
                    if (len_full > 32'(MAX_WORDS)) begin
                        state_nxt = ERROR;
                    end else if (len_full == 32'd0) begin
                        state_nxt = CHK;
                    end else begin
                        state_nxt = DATA;
                    end
                end
            end
            DATA: begin
                if (last_word) begin
                    state_nxt = CHK;
                end
            end
            CHK: begin
                if (acc) begin
                    state_nxt = (in_byte == csum) ? DONE : ERROR;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            len_idx       <= '0;
            words_written <= '0;
            mem_addr      <= '0;
        end else if (start_ok) begin
            len_idx       <= '0;
            words_written <= '0;
        end else begin
            if (len_acc) begin
                len_idx <= len_idx + 2'd1;
            end
            // Address and count move together so both are valid with mem_we
            if (word_last) begin
                mem_addr      <= word_addr(BASE_ADDR, 32'(words_written));
                words_written <= words_written + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (len_acc) begin
            case (len_idx)
                2'd0:    len[7:0]   <= in_byte;
                2'd1:    len[15:8]  <= in_byte;
                2'd2:    len[23:16] <= in_byte;
                default: len[31:24] <= in_byte;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: two instances (base 0 and base 0x100) share
// one byte stream and are checked against a frame-level write scoreboard.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_byte = 8'h00;

    logic        in_ready_a, mem_we_a, busy_a, done_a, error_a, cpu_hold_a;
    logic [31:0] mem_addr_a, mem_wdata_a;
    logic [14:0] ww_a;
    logic        in_ready_b, mem_we_b, busy_b, done_b, error_b, cpu_hold_b;
    logic [31:0] mem_addr_b, mem_wdata_b;
    logic [14:0] ww_b;

    imem_loader #(.BASE_ADDR(32'h0000_0000)) dut_a (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
        .in_byte(in_byte), .in_ready(in_ready_a), .mem_we(mem_we_a),
        .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a), .busy(busy_a),
        .done(done_a), .error(error_a), .cpu_hold(cpu_hold_a),
        .words_written(ww_a)
    );

    imem_loader #(.BASE_ADDR(32'h0000_0100)) dut_b (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
        .in_byte(in_byte), .in_ready(in_ready_b), .mem_we(mem_we_b),
        .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b), .busy(busy_b),
        .done(done_b), .error(error_b), .cpu_hold(cpu_hold_b),
        .words_written(ww_b)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          due;
        logic [31:0] off;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_q[$];
    logic [31:0] pay_q[$];
    int          vecs = 0;
    int          miss = 0;
    int          ww_exp = 0;
    logic [31:0] hold_a = 32'h0, hold_b = 32'h0, hold_d = 32'h0;
    bit          cmp_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            miss++;
            $display("FAIL %s: got %h, want %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Every cycle: mem_we must match the scoreboard's due writes exactly.
    task automatic compare_loop();
        forever begin
            @(negedge clk);
            if (!reset && cmp_en) begin
                if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                    hold_a = exp_q[0].off;
                    hold_b = 32'h100 + exp_q[0].off;
                    hold_d = exp_q[0].data;
                    ww_exp++;
                    chk("we_a", 32'(mem_we_a), 32'd1);
                    chk("we_b", 32'(mem_we_b), 32'd1);
                    void'(exp_q.pop_front());
                end else begin
                    chk("no_we_a", 32'(mem_we_a), 32'd0);
                    chk("no_we_b", 32'(mem_we_b), 32'd0);
                end
                chk("addr_a", mem_addr_a, hold_a);
                chk("addr_b", mem_addr_b, hold_b);
                chk("wdata_a", mem_wdata_a, hold_d);
                chk("wdata_b", mem_wdata_b, hold_d);
                chk("ww_a", 32'(ww_a), 32'(ww_exp));
                chk("ww_b", 32'(ww_b), 32'(ww_exp));
                chk("ready_is_busy", 32'(in_ready_a), 32'(busy_a));
                chk("hold_vs_done", 32'(cpu_hold_a), 32'(!done_a));
            end
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_in_ready"}, 32'(in_ready_a), 32'd0);
        chk({tag, "_mem_we"}, 32'(mem_we_a), 32'd0);
        chk({tag, "_busy"}, 32'(busy_a), 32'd0);
        chk({tag, "_done"}, 32'(done_a), 32'd0);
        chk({tag, "_error"}, 32'(error_a), 32'd0);
        chk({tag, "_addr_a"}, mem_addr_a, 32'd0);
        chk({tag, "_addr_b"}, mem_addr_b, 32'd0);
        chk({tag, "_wdata"}, mem_wdata_a, 32'd0);
        chk({tag, "_ww"}, 32'(ww_a), 32'd0);
        chk({tag, "_cpu_hold"}, 32'(cpu_hold_a), 32'd1);
    endtask

    task automatic check_status(input string tag, input logic d, input logic e,
                                input logic h, input int ww);
        chk({tag, "_done_a"}, 32'(done_a), 32'(d));
        chk({tag, "_done_b"}, 32'(done_b), 32'(d));
        chk({tag, "_error_a"}, 32'(error_a), 32'(e));
        chk({tag, "_error_b"}, 32'(error_b), 32'(e));
        chk({tag, "_cpu_hold"}, 32'(cpu_hold_a), 32'(h));
        chk({tag, "_busy"}, 32'(busy_a), 32'd0);
        chk({tag, "_ww"}, 32'(ww_a), 32'(ww));
        chk({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        ww_exp = 0;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int stall);
        int guard;
        bit v;
        guard = 0;
        forever begin
            @(negedge clk);
            v = (stall == 0) || ($urandom_range(99) >= stall);
            in_valid = v;
            in_byte  = v ? b : 8'($urandom);
            if (stall == 0) begin
                chk("in_ready_a", 32'(in_ready_a), 32'd1);
                chk("in_ready_b", 32'(in_ready_b), 32'd1);
            end
            if (v && in_ready_a) break;
            guard++;
            if (guard > 100) begin
                vecs++;
                miss++;
                $display("FAIL byte_timeout: byte %h not taken, in_ready=%b", b, in_ready_a);
                break;
            end
        end
    endtask

    // Sends a frame from pay_q; stop_after >= 0 truncates after that many payload bytes.
    task automatic send_frame(input logic [31:0] n, input logic [7:0] chk_byte,
                              input int stall, input int stop_after);
        int  sent;
        bit  stopped;
        sent    = 0;
        stopped = 1'b0;
        for (int i = 0; i < 4; i++) send_byte(n[8*i +: 8], stall);
        if (n <= 32'd16384) begin
            for (int k = 0; k < int'(n) && !stopped; k++) begin
                for (int j = 0; j < 4 && !stopped; j++) begin
                    if (stop_after >= 0 && sent == stop_after) begin
                        stopped = 1'b1;
                    end else begin
                        send_byte(pay_q[k][8*j +: 8], stall);
                        sent++;
                        if (j == 3) exp_q.push_back('{due: cyc + 1, off: 32'(4 * k), data: pay_q[k]});
                    end
                end
            end
            if (!stopped) send_byte(chk_byte, stall);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        fork
            compare_loop();
        join_none

        #1;
        check_reset_vals("por");
        @(negedge clk);
        #2 reset = 1'b0;
        cmp_en = 1'b1;

        // Two-word load with correct checksum
        pay_q = '{32'h0050_0013, 32'h0010_0093};
        pulse_start();
        send_frame(32'd2, 8'hC0, 0, -1);
        check_status("two_word", 1'b1, 1'b0, 1'b0, 2);
        chk("two_word_last_addr_a", mem_addr_a, 32'h0000_0004);
        chk("two_word_last_addr_b", mem_addr_b, 32'h0000_0104);
        chk("two_word_last_data", mem_wdata_a, 32'h0010_0093);

        // Bytes offered while not ready are ignored
        repeat (3) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_byte  = 8'hAA;
        end
        @(negedge clk);
        in_valid = 1'b0;
        check_status("idle_bytes", 1'b1, 1'b0, 1'b0, 2);

        // Restart from DONE, then a bad checksum
        pulse_start();
        chk("restart_done", 32'(done_a), 32'd0);
        chk("restart_hold", 32'(cpu_hold_a), 32'd1);
        chk("restart_busy", 32'(busy_a), 32'd1);
        send_frame(32'd2, 8'hC1, 0, -1);
        check_status("bad_chk", 1'b0, 1'b1, 1'b1, 2);

        // Zero-length frame
        pay_q.delete();
        pulse_start();
        send_frame(32'd0, 8'h00, 0, -1);
        check_status("zero_len", 1'b1, 1'b0, 1'b0, 0);

        // Length overflow: error right after the last length byte
        pulse_start();
        send_frame(32'h0000_4001, 8'h00, 0, -1);
        check_status("overflow", 1'b0, 1'b1, 1'b1, 0);

        // Stalled one-word load with a stray start while busy
        pay_q = '{32'hDEAD_BEEF};
        pulse_start();
        fork
            begin
                repeat (5) @(negedge clk);
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
        join_none
        send_frame(32'd1, 8'h22, 50, -1);
        check_status("stalled", 1'b1, 1'b0, 1'b0, 1);
        chk("stalled_data", mem_wdata_a, 32'hDEAD_BEEF);

        // Reset after six payload bytes of a three-word load
        pay_q = '{32'h1122_3344, 32'h5566_7788, 32'h99AA_BBCC};
        pulse_start();
        send_frame(32'd3, 8'hCC, 0, 6);
        chk("partial_ww", 32'(ww_a), 32'd1);
        chk("partial_data", mem_wdata_a, 32'h1122_3344);
        #2 reset = 1'b1;
        #1 check_reset_vals("mid_reset");
        exp_q.delete();
        hold_a = 32'h0;
        hold_b = 32'h0;
        hold_d = 32'h0;
        ww_exp = 0;
        @(negedge clk);
        #2 reset = 1'b0;
        pulse_start();
        send_frame(32'd3, 8'hCC, 0, -1);
        check_status("reload", 1'b1, 1'b0, 1'b0, 3);
        chk("reload_addr_a", mem_addr_a, 32'h0000_0008);

        // Back-to-back four-word stream
        pay_q = '{32'h0302_0100, 32'h0706_0504, 32'h0B0A_0908, 32'h0F0E_0D0C};
        pulse_start();
        send_frame(32'd4, 8'h00, 0, -1);
        check_status("b2b", 1'b1, 1'b0, 1'b0, 4);
        chk("b2b_addr_b", mem_addr_b, 32'h0000_010C);
        chk("b2b_addr_a", mem_addr_a, 32'h0000_000C);
        chk("b2b_data", mem_wdata_b, 32'h0F0E_0D0C);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule
